// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the round-robin FIFO enqueue arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 4;

  // Index width never collapses to zero, even for two producers.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int REQ_IDX_W = idx_width(DEF_N_REQ);
  localparam int BURST_W   = $clog2(DEF_MAX_BURST + 1);

endpackage

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// Round-robin pick: rotate the request vector so the search starts just after
// last_owner, take the lowest set bit, then map the offset back to a producer index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  always_comb begin
    start   = (last_owner == IDX_W'(N_REQ - 1)) ? '0 : last_owner + 1'b1;
    doubled = {req, req};
    rotated = doubled[start +: N_REQ];
  end

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = IDX_W'(k);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sum    = {1'b0, start} + {1'b0, offset};
    winner = (sum >= (IDX_W + 1)'(N_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(N_REQ))
                                          : sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Write-side arbiter sharing one FIFO among N_REQ producers: one bubble per grant,
// bursts of up to MAX_BURST beats, stalls on full, releases early when the owner drops req.
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDX_W     = idx_width(N_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    fifo_full,
  output logic                    fifo_enq,
  output logic [DATA_W-1:0]       fifo_data,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_id
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             transfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (owner_q),
    .winner     (pick_idx),
    .found      (pick_found)
  );

  // owner_q doubles as last_owner once the grant is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= IDX_W'(N_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    case (state_q)
      ARB: begin
        if (pick_found) begin
          state_d = OWN;
          owner_d = pick_idx;
          burst_d = '0;
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d = ARB;
          burst_d = '0;
        end else if (transfer) begin
          if (burst_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = ARB;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Outputs are forced to their reset values during reset so a burst aborts cleanly.
  always_comb begin
    transfer = 1'b0;
    if (!reset && state_q == OWN) begin
      transfer = req[owner_q] & ~fifo_full;
    end
    fifo_enq    = transfer;
    ack         = transfer ? (N_REQ'(1) << owner_q) : '0;
    fifo_data   = transfer ? req_data[owner_q*DATA_W +: DATA_W] : '0;
    grant_valid = !reset && (state_q == OWN);
    grant_id    = reset ? IDX_W'(N_REQ - 1) : owner_q;
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Randomised scoreboard bench for fifo_enq_arbiter with a behavioural grant model,
// producer beat queues and an 8-deep FIFO occupancy model driving fifo_full.
module tb_fifo_enq_arbiter;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int MB     = 4;
  localparam int FDEPTH = 8;
  localparam int PMAX   = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic            fifo_full;
  logic            fifo_enq;
  logic [DW-1:0]   fifo_data;
  logic            grant_valid;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  fifo_enq_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .fifo_full   (fifo_full),
    .fifo_enq    (fifo_enq),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  typedef struct {
    logic [N-1:0]  ack;
    logic          enq;
    logic [DW-1:0] data;
    logic          gv;
    logic [1:0]    gid;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] data_q[$];
  int            total = 0;
  int            bad   = 0;

  logic [DW-1:0] prod_mem[N][PMAX];
  int            prod_head[N];
  int            prod_tail[N];
  int            fifo_cnt;

  bit            m_granted;
  int            m_owner;
  int            m_cnt;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, act, want);
    end
  endtask

  task automatic load(input int p, input int nbeats, input int base);
    if (prod_head[p] == prod_tail[p]) begin
      prod_head[p] = 0;
      prod_tail[p] = 0;
    end
    for (int k = 0; k < nbeats; k++) begin
      if (prod_tail[p] < PMAX) begin
        prod_mem[p][prod_tail[p]] = DW'(base + k);
        prod_tail[p]++;
      end
    end
  endtask

  task automatic clear_producers();
    for (int i = 0; i < N; i++) begin
      prod_head[i] = 0;
      prod_tail[i] = 0;
    end
  endtask

  // Drive one cycle, predict the DUT response, then advance the model past the next edge.
  task automatic applyStimulus(input bit rst, input int deq_pct, input int drop_pct);
    exp_t         e;
    logic [N-1:0] r;
    int           nxt;
    @(posedge clk);
    #1;
    reset    = rst;
    r        = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      if (prod_head[i] != prod_tail[i]) begin
        req_data[i*DW +: DW] = prod_mem[i][prod_head[i]];
        if (int'($urandom_range(99)) >= drop_pct) r[i] = 1'b1;
      end
    end
    req       = r;
    fifo_full = (fifo_cnt == FDEPTH);

    e.enq  = !rst && m_granted && r[m_owner] && !fifo_full;
    e.ack  = '0;
    e.data = '0;
    if (e.enq) begin
      e.ack[m_owner] = 1'b1;
      e.data         = prod_mem[m_owner][prod_head[m_owner]];
    end
    e.gv  = !rst && m_granted;
    e.gid = rst ? 2'(N - 1) : 2'(m_owner);
    exp_q.push_back(e);

    if (rst) begin
      fifo_cnt = 0;
    end else begin
      if (fifo_cnt > 0 && int'($urandom_range(99)) < deq_pct) fifo_cnt--;
      if (e.enq) begin
        data_q.push_back(e.data);
        prod_head[m_owner]++;
        fifo_cnt++;
      end
    end

    if (rst) begin
      m_granted = 1'b0;
      m_owner   = N - 1;
      m_cnt     = 0;
    end else if (!m_granted) begin
      for (int k = 1; k <= N; k++) begin
        nxt = (m_owner + k) % N;
        if (r[nxt] && !m_granted) begin
          m_owner   = nxt;
          m_granted = 1'b1;
          m_cnt     = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_granted = 1'b0;
    end else if (e.enq) begin
      m_cnt++;
      if (m_cnt == MB) m_granted = 1'b0;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("ack", 32'(ack), 32'(e.ack));
    cmp("fifo_enq", 32'(fifo_enq), 32'(e.enq));
    cmp("fifo_data", 32'(fifo_data), 32'(e.data));
    cmp("grant_valid", 32'(grant_valid), 32'(e.gv));
    cmp("grant_id", 32'(grant_id), 32'(e.gid));
    if (fifo_enq === 1'b1) begin
      if (data_q.size() == 0) begin
        cmp("unexpected_enq", 32'(1), 32'(0));
      end else begin
        cmp("enq_order", 32'(fifo_data), 32'(data_q.pop_front()));
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    fifo_cnt  = 0;
    m_granted = 1'b0;
    m_owner   = N - 1;
    m_cnt     = 0;
    clear_producers();

    $display("[TB] reset with all producers requesting, then full rotation");
    for (int i = 0; i < N; i++) load(i, 8, i * 16);
    repeat (2) applyStimulus(1'b1, 100, 0);
    repeat (45) applyStimulus(1'b0, 100, 0);

    $display("[TB] single producer burst 0x11..0x16");
    clear_producers();
    load(0, 6, 8'h11);
    repeat (15) applyStimulus(1'b0, 100, 0);

    $display("[TB] backpressure with no dequeue");
    applyStimulus(1'b1, 0, 0);
    clear_producers();
    for (int i = 0; i < N; i++) load(i, 8, i * 16 + 8'h40);
    repeat (20) applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b0, 100, 0);
    repeat (6) applyStimulus(1'b0, 0, 0);

    $display("[TB] early release by producer 1");
    applyStimulus(1'b1, 100, 0);
    clear_producers();
    load(1, 2, 8'hA0);
    load(3, 4, 8'hB0);
    repeat (12) applyStimulus(1'b0, 100, 0);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1'b1, 100, 0);
    clear_producers();
    load(2, 6, 8'hC0);
    repeat (3) applyStimulus(1'b0, 100, 0);
    load(0, 2, 8'hD0);
    applyStimulus(1'b1, 100, 0);
    repeat (12) applyStimulus(1'b0, 100, 0);

    $display("[TB] randomised traffic");
    for (int blk = 0; blk < 15; blk++) begin
      int deq_pct;
      deq_pct = int'($urandom_range(100));
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < N; i++) begin
          if (prod_head[i] == prod_tail[i] && $urandom_range(99) < 20)
            load(i, int'($urandom_range(10, 1)), int'($urandom_range(255)));
        end
        applyStimulus($urandom_range(499) == 0, deq_pct, 10);
      end
    end

    @(negedge clk);
    #1;
    cmp("exp_queue_drained", 32'(exp_q.size()), 32'(0));
    cmp("enq_queue_drained", 32'(data_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
